// File: rtl/mult_div_pkg.sv
// Shared definitions for the multicycle multiply/divide unit:
// state encoding and iteration count, also used by the control unit.
package mult_div_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 6;
    localparam int MD_ITER  = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2
    } md_state_t;

endpackage

// File: rtl/mult_div_if.sv
// Control/operand/result bundle between the datapath and mult_div.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start_mult, start_div, a_in, b_in,
        input  hi_out, lo_out, busy, done, div_zero
    );

    modport slave (
        input  start_mult, start_div, a_in, b_in,
        output hi_out, lo_out, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_div_step.sv
// One combinational restoring-division step on unsigned magnitudes:
// shift the next dividend bit into the partial remainder, subtract the
// divisor when it fits, and emit the resulting quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // Trial subtraction; the borrow bit decides whether to restore.
    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = w_shift - {1'b0, i_dvs};
        o_q     = ~w_diff[WIDTH];
        o_rem   = o_q ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    end
endmodule

// File: rtl/mult_div.sv
// Multicycle signed MULT/DIV unit. Booth radix-2 multiply and restoring
// divide on magnitudes, one step per clock, WIDTH steps per operation.
// Shared working registers: r_acc (Booth accumulator / partial remainder),
// r_q (multiplier / dividend shifting into quotient), r_m (multiplicand /
// divisor magnitude).
module mult_div
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic clk,
    input  logic reset,
    mult_div_if.slave bus
);
    md_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_qm1;
    logic [WIDTH:0]   r_m;
    logic             r_neg_q, r_neg_r;
    logic             r_dz_pend;
    logic             r_div_zero;
    logic             r_done;
    logic [WIDTH-1:0] r_hi, r_lo;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_booth_acc;
    logic [WIDTH-1:0] w_booth_q;
    logic [WIDTH-1:0] w_div_rem;
    logic             w_div_bit;
    logic [WIDTH-1:0] w_div_q;

    assign w_accept = (r_state == MD_IDLE) && (bus.start_mult || bus.start_div);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_a_mag  = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
    assign w_b_mag  = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;

    // Booth step: add/subtract multiplicand per {q0, q-1}, then arithmetic shift.
    always_comb begin
        w_sum = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_acc + r_m;
            2'b10:   w_sum = r_acc - r_m;
            default: w_sum = r_acc;
        endcase
        w_booth_acc = {w_sum[WIDTH], w_sum[WIDTH:1]};
        w_booth_q   = {w_sum[0], r_q[WIDTH-1:1]};
    end

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem (r_acc[WIDTH-1:0]),
        .i_bit (r_q[WIDTH-1]),
        .i_dvs (r_m[WIDTH-1:0]),
        .o_rem (w_div_rem),
        .o_q   (w_div_bit)
    );
    assign w_div_q = {r_q[WIDTH-2:0], w_div_bit};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= MD_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state: start_mult wins a tie; divide-by-zero leaves after one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: begin
                if (bus.start_mult)     w_state_nxt = MD_MULT;
                else if (bus.start_div) w_state_nxt = MD_DIV;
            end
            MD_MULT: if (w_last) w_state_nxt = MD_IDLE;
            MD_DIV:  if (r_dz_pend || w_last) w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    // Operand capture, iteration, sign fix-up and result/flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_qm1      <= 1'b0;
            r_m        <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz_pend  <= 1'b0;
            r_div_zero <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (w_accept) begin
                        r_div_zero <= 1'b0;
                        r_cnt      <= '0;
                        r_acc      <= '0;
                        r_qm1      <= 1'b0;
                        if (bus.start_mult) begin
                            r_m       <= {bus.a_in[WIDTH-1], bus.a_in};
                            r_q       <= bus.b_in;
                            r_dz_pend <= 1'b0;
                        end else begin
                            r_m       <= {1'b0, w_b_mag};
                            r_q       <= w_a_mag;
                            r_neg_q   <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
                            r_neg_r   <= bus.a_in[WIDTH-1];
                            r_dz_pend <= (bus.b_in == '0);
                        end
                    end
                end
                MD_MULT: begin
                    r_acc <= w_booth_acc;
                    r_q   <= w_booth_q;
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_hi   <= w_booth_acc[WIDTH-1:0];
                        r_lo   <= w_booth_q;
                        r_done <= 1'b1;
                    end
                end
                MD_DIV: begin
                    if (r_dz_pend) begin
                        r_dz_pend  <= 1'b0;
                        r_div_zero <= 1'b1;
                        r_done     <= 1'b1;
                    end else begin
                        r_acc <= {1'b0, w_div_rem};
                        r_q   <= w_div_q;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            // Quotient truncates toward zero, remainder follows dividend.
                            r_lo   <= r_neg_q ? -w_div_q : w_div_q;
                            r_hi   <= r_neg_r ? -w_div_rem : w_div_rem;
                            r_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi_out   = r_hi;
    assign bus.lo_out   = r_lo;
    assign bus.busy     = (r_state != MD_IDLE);
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div.sv
// Directed self-checking bench for mult_div.
module tb_mult_div;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    mult_div_if #(.WIDTH(32)) bus ();
    mult_div #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Drive a start at the current negedge; returns at the negedge after the accepting edge.
    task automatic launch(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        bus.start_mult = m; bus.start_div = d; bus.a_in = a; bus.b_in = b;
        @(negedge clk);
        bus.start_mult = 1'b0; bus.start_div = 1'b0;
    endtask

    // Cycles from the accepting edge until done is seen; -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (bus.done !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset;
        n_checks++;
        if ({bus.hi_out, bus.lo_out, bus.busy, bus.done, bus.div_zero} !== 67'd0) begin
            n_errors++; $display("FAIL reset_state: got %h expected 0", {bus.hi_out, bus.lo_out, bus.busy, bus.done, bus.div_zero});
        end
        @(negedge clk); reset = 1'b0; @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_errors++; $display("FAIL reset_release: busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_mult;
        int cyc;
        logic [31:0] va [3] = '{32'd7, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] vb [3] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] eh [3] = '{32'hFFFFFFFF, 32'h40000000, 32'h00000000};
        logic [31:0] el [3] = '{32'hFFFFFFEB, 32'h00000000, 32'h00000001};
        for (int i = 0; i < 3; i++) begin
            launch(1'b1, 1'b0, va[i], vb[i]);
            n_checks++;
            if (bus.busy !== 1'b1) begin
                n_errors++; $display("FAIL mult_busy[%0d]: got %b expected 1", i, bus.busy);
            end
            wait_done(cyc);
            n_checks++;
            if (cyc !== 32) begin
                n_errors++; $display("FAIL mult_latency[%0d]: got %0d expected 32", i, cyc);
            end
            n_checks++;
            if (bus.hi_out !== eh[i] || bus.lo_out !== el[i] || bus.busy !== 1'b0) begin
                n_errors++; $display("FAIL mult_result[%0d]: got hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=0",
                                     i, bus.hi_out, bus.lo_out, bus.busy, eh[i], el[i]);
            end
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0) begin
                n_errors++; $display("FAIL mult_done_pulse[%0d]: got %b expected 0", i, bus.done);
            end
        end
    endtask

    task automatic test_div;
        int cyc;
        logic [31:0] va [4] = '{32'hFFFFFFF9, 32'h80000000, 32'd100, 32'd7};
        logic [31:0] vb [4] = '{32'd2, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFE};
        logic [31:0] eh [4] = '{32'hFFFFFFFF, 32'd0, 32'd2, 32'd1};
        logic [31:0] el [4] = '{32'hFFFFFFFD, 32'h80000000, 32'd14, 32'hFFFFFFFD};
        for (int i = 0; i < 4; i++) begin
            launch(1'b0, 1'b1, va[i], vb[i]);
            wait_done(cyc);
            n_checks++;
            if (cyc !== 32) begin
                n_errors++; $display("FAIL div_latency[%0d]: got %0d expected 32", i, cyc);
            end
            n_checks++;
            if (bus.hi_out !== eh[i] || bus.lo_out !== el[i] || bus.div_zero !== 1'b0) begin
                n_errors++; $display("FAIL div_result[%0d]: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=0",
                                     i, bus.hi_out, bus.lo_out, bus.div_zero, eh[i], el[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_div_zero;
        int cyc;
        launch(1'b0, 1'b1, 32'd5, 32'd2);
        wait_done(cyc);
        n_checks++;
        if (bus.hi_out !== 32'd1 || bus.lo_out !== 32'd2) begin
            n_errors++; $display("FAIL dz_setup: got hi=%h lo=%h expected hi=1 lo=2", bus.hi_out, bus.lo_out);
        end
        @(negedge clk);
        launch(1'b0, 1'b1, 32'd5, 32'd0);
        wait_done(cyc);
        n_checks++;
        if (cyc !== 1) begin
            n_errors++; $display("FAIL dz_latency: got %0d expected 1", cyc);
        end
        n_checks++;
        if (bus.div_zero !== 1'b1 || bus.hi_out !== 32'd1 || bus.lo_out !== 32'd2 || bus.busy !== 1'b0) begin
            n_errors++; $display("FAIL dz_result: got dz=%b hi=%h lo=%h busy=%b expected dz=1 hi=1 lo=2 busy=0",
                                 bus.div_zero, bus.hi_out, bus.lo_out, bus.busy);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.div_zero !== 1'b1 || bus.done !== 1'b0) begin
            n_errors++; $display("FAIL dz_sticky: got dz=%b done=%b expected dz=1 done=0", bus.div_zero, bus.done);
        end
        launch(1'b1, 1'b0, 32'd2, 32'd3);
        n_checks++;
        if (bus.div_zero !== 1'b0) begin
            n_errors++; $display("FAIL dz_clear: got %b expected 0", bus.div_zero);
        end
        wait_done(cyc);
        n_checks++;
        if (bus.lo_out !== 32'd6 || bus.hi_out !== 32'd0) begin
            n_errors++; $display("FAIL dz_next_mult: got hi=%h lo=%h expected hi=0 lo=6", bus.hi_out, bus.lo_out);
        end
        @(negedge clk);
    endtask

    task automatic test_start_priority;
        int ndone;
        launch(1'b1, 1'b1, 32'd6, 32'd4);
        repeat (3) @(negedge clk);
        launch(1'b0, 1'b1, 32'd9, 32'd2);
        ndone = 0;
        repeat (60) begin
            if (bus.done === 1'b1) ndone++;
            @(negedge clk);
        end
        n_checks++;
        if (ndone !== 1) begin
            n_errors++; $display("FAIL busy_ignore_done_count: got %0d expected 1", ndone);
        end
        n_checks++;
        if (bus.hi_out !== 32'd0 || bus.lo_out !== 32'd24 || bus.busy !== 1'b0) begin
            n_errors++; $display("FAIL priority_result: got hi=%h lo=%h busy=%b expected hi=0 lo=24 busy=0",
                                 bus.hi_out, bus.lo_out, bus.busy);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        launch(1'b1, 1'b0, 32'd3, 32'd5);
        wait_done(cyc);
        launch(1'b1, 1'b0, 32'd2, 32'hFFFFFFFC);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.lo_out !== 32'd15) begin
            n_errors++; $display("FAIL b2b_accept: got busy=%b lo=%h expected busy=1 lo=f", bus.busy, bus.lo_out);
        end
        wait_done(cyc);
        n_checks++;
        if (cyc !== 32 || bus.hi_out !== 32'hFFFFFFFF || bus.lo_out !== 32'hFFFFFFF8) begin
            n_errors++; $display("FAIL b2b_result: got cyc=%0d hi=%h lo=%h expected cyc=32 hi=ffffffff lo=fffffff8",
                                 cyc, bus.hi_out, bus.lo_out);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int ndone;
        launch(1'b1, 1'b0, 32'h00012345, 32'h00000777);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi_out !== 32'd0 || bus.lo_out !== 32'd0) begin
            n_errors++; $display("FAIL reset_mid_abort: got busy=%b done=%b hi=%h lo=%h expected all 0",
                                 bus.busy, bus.done, bus.hi_out, bus.lo_out);
        end
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone !== 0 || bus.busy !== 1'b0 || bus.hi_out !== 32'd0 || bus.lo_out !== 32'd0) begin
            n_errors++; $display("FAIL reset_mid_after: got dones=%0d busy=%b hi=%h lo=%h expected 0 0 0 0",
                                 ndone, bus.busy, bus.hi_out, bus.lo_out);
        end
    endtask

    initial begin
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.a_in       = '0;
        bus.b_in       = '0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_start_priority();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
